// File: rtl/serial_accumulator_mc.sv
// Frame accumulator: loads K words of W bits in parallel and sums L words per cycle into an SW-bit result.
// Supports per-frame signed/unsigned mode, chained frames with a sticky overflow flag, and back-to-back loads.
module serial_accumulator_mc #(
   parameter int W = 6,
   parameter int K = 4,
   parameter int L = 1,
   localparam int SW = W + $clog2(K)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [W*K-1:0] din,
   input  logic          pl,
   input  logic          sgn,
   input  logic          chain,
   output logic          busy,
   output logic          ready,
   output logic [SW-1:0] sum,
   output logic          ovf,
   output logic          drop,
   output logic [1:0]    dbg_state
);

   localparam int C  = K / L;
   localparam int IW = (C > 1) ? $clog2(C) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]     state;
   logic [W*K-1:0] din_q;
   logic           sgn_q;
   logic           chain_q;
   logic [SW-1:0]  acc;
   logic [IW-1:0]  idx;

   logic [SW-1:0]  nxt_acc;
   logic           nxt_ovf;
   logic [W-1:0]   word;
   logic [SW-1:0]  ext;
   logic [SW:0]    add;

   // Handshake: pl is a request sampled on every edge; it is accepted only in IDLE or DONE,
   // otherwise it is dropped and drop pulses. ready pulses for exactly one cycle per completed frame.

   // Ripple the L words of this cycle through the accumulator, flagging any overflowing addition.
   always_comb begin
      nxt_acc = acc;
      nxt_ovf = 1'b0;
      word    = '0;
      ext     = '0;
      add     = '0;
      for (int j = 0; j < L; j++) begin
         word = din_q[(int'(idx) * L + j) * W +: W];
         ext  = {{(SW-W){sgn_q & word[W-1]}}, word};
         add  = {1'b0, nxt_acc} + {1'b0, ext};
         if (sgn_q)
            nxt_ovf = nxt_ovf | ((nxt_acc[SW-1] == ext[SW-1]) && (add[SW-1] != nxt_acc[SW-1]));
         else
            nxt_ovf = nxt_ovf | add[SW];
         nxt_acc = add[SW-1:0];
      end
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state   <= IDLE;
         din_q   <= '0;
         sgn_q   <= 1'b0;
         chain_q <= 1'b0;
         acc     <= '0;
         idx     <= '0;
         sum     <= '0;
         busy    <= 1'b0;
         ready   <= 1'b0;
         ovf     <= 1'b0;
         drop    <= 1'b0;
      end else begin
         ready <= 1'b0;
         drop  <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (pl) begin
                  din_q   <= din;
                  sgn_q   <= sgn;
                  chain_q <= chain;
                  acc     <= chain ? sum : '0;
                  idx     <= '0;
                  state   <= RUN;
                  busy    <= 1'b1;
                  if (!chain)
                     ovf <= 1'b0;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            RUN: begin
               if (pl)
                  drop <= 1'b1;
               acc <= nxt_acc;
               idx <= idx + IW'(1);
               if (chain_q && nxt_ovf)
                  ovf <= 1'b1;
               if (idx == IW'(C - 1)) begin
                  sum   <= nxt_acc;
                  ready <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_serial_accumulator_mc.sv
// Directed bench for serial_accumulator_mc: one L=1 instance and one L=2 instance on a shared clock and reset.
module tb_serial_accumulator_mc;

   localparam int W  = 6;
   localparam int K  = 4;
   localparam int SW = W + $clog2(K);

   logic          clk = 1'b0;
   logic          rstn = 1'b1;

   logic [W*K-1:0] din = '0;
   logic          pl = 1'b0, sgn = 1'b0, chain = 1'b0;
   logic          busy, ready, ovf, drop;
   logic [SW-1:0] sum;
   logic [1:0]    st1;

   logic [W*K-1:0] din2 = '0;
   logic          pl2 = 1'b0, sgn2 = 1'b0, chain2 = 1'b0;
   logic          busy2, ready2, ovf2, drop2;
   logic [SW-1:0] sum2;
   logic [1:0]    st2;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_accumulator_mc #(.W(W), .K(K), .L(1)) dut1 (
      .clk(clk), .rstn(rstn), .din(din), .pl(pl), .sgn(sgn), .chain(chain),
      .busy(busy), .ready(ready), .sum(sum), .ovf(ovf), .drop(drop), .dbg_state(st1)
   );

   serial_accumulator_mc #(.W(W), .K(K), .L(2)) dut2 (
      .clk(clk), .rstn(rstn), .din(din2), .pl(pl2), .sgn(sgn2), .chain(chain2),
      .busy(busy2), .ready(ready2), .sum(sum2), .ovf(ovf2), .drop(drop2), .dbg_state(st2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full frame on the L=1 instance: load edge E0, then E1..E4 with the result at E4.
   task automatic do_frame(input logic [W-1:0] w0, w1, w2, w3, input logic s, c,
                           input logic [SW-1:0] exp_sum, input logic exp_ovf,
                           input logic chk_clear, input string name);
      din = {w3, w2, w1, w0}; sgn = s; chain = c; pl = 1'b1;
      step();
      pl = 1'b0;
      n_vec++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy@E0 got %b want 1", name, busy); end
      if (chk_clear) begin
         n_vec++;
         if (ovf !== 1'b0) begin n_err++; $display("FAIL %s ovf_clear@E0 got %b want 0", name, ovf); end
      end
      for (int i = 1; i < 4; i++) begin
         step();
         n_vec++;
         if (busy !== 1'b1 || ready !== 1'b0) begin
            n_err++; $display("FAIL %s run@E%0d busy=%b ready=%b want 1/0", name, i, busy, ready);
         end
      end
      step();
      n_vec++;
      if (ready !== 1'b1 || busy !== 1'b0 || sum !== exp_sum || ovf !== exp_ovf) begin
         n_err++;
         $display("FAIL %s done ready=%b busy=%b sum=%h ovf=%b want 1/0/%h/%b",
                  name, ready, busy, sum, ovf, exp_sum, exp_ovf);
      end
      step();
      n_vec++;
      if (ready !== 1'b0 || sum !== exp_sum) begin
         n_err++; $display("FAIL %s after ready=%b sum=%h want 0/%h", name, ready, sum, exp_sum);
      end
   endtask

   task automatic test_reset();
      #1;
      n_vec++;
      if (sum !== '0 || ready !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0 || drop !== 1'b0 ||
          sum2 !== '0 || busy2 !== 1'b0 || ready2 !== 1'b0) begin
         n_err++; $display("FAIL reset outputs sum=%h rdy=%b busy=%b ovf=%b drop=%b want all 0",
                           sum, ready, busy, ovf, drop);
      end
      pl = 1'b1;
      step();
      step();
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_pl_ignored busy=%b want 0", busy); end
      pl = 1'b0;
      rstn = 1'b0;
      step();
   endtask

   task automatic test_unsigned();
      do_frame(6'd1, 6'd2, 6'd3, 6'd4, 1'b0, 1'b0, 8'd10, 1'b0, 1'b0, "unsigned");
      do_frame(6'd63, 6'd63, 6'd63, 6'd63, 1'b0, 1'b0, 8'd252, 1'b0, 1'b0, "unsigned_max");
   endtask

   task automatic test_signed();
      do_frame(6'h3F, 6'h20, 6'h05, 6'h0A, 1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, "signed");
   endtask

   task automatic test_chain();
      do_frame(6'd1, 6'd2, 6'd3, 6'd4, 1'b0, 1'b0, 8'd10, 1'b0, 1'b0, "chain_base");
      do_frame(6'd1, 6'd1, 6'd1, 6'd1, 1'b0, 1'b1, 8'd14, 1'b0, 1'b0, "chain_add");
      do_frame(6'd63, 6'd63, 6'd63, 6'd63, 1'b0, 1'b0, 8'd252, 1'b0, 1'b0, "chain_base2");
      do_frame(6'd63, 6'd63, 6'd63, 6'd63, 1'b0, 1'b1, 8'd248, 1'b1, 1'b0, "chain_ovf");
      n_vec++;
      if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", ovf); end
      do_frame(6'd1, 6'd2, 6'd3, 6'd4, 1'b0, 1'b0, 8'd10, 1'b0, 1'b1, "chain_clear");
   endtask

   task automatic test_drop();
      din = {6'd4, 6'd3, 6'd2, 6'd1}; sgn = 1'b0; chain = 1'b0; pl = 1'b1;
      step();                       // E0
      pl = 1'b0;
      din = {6'd9, 6'd9, 6'd9, 6'd9};
      step();                       // E1
      pl = 1'b1;
      step();                       // E2 samples the stray pl
      pl = 1'b0;
      n_vec++;
      if (drop !== 1'b1) begin n_err++; $display("FAIL drop_pulse got %b want 1", drop); end
      step();                       // E3
      n_vec++;
      if (drop !== 1'b0 || ready !== 1'b0) begin
         n_err++; $display("FAIL drop_clear drop=%b ready=%b want 0/0", drop, ready);
      end
      step();                       // E4
      n_vec++;
      if (ready !== 1'b1 || sum !== 8'd10) begin
         n_err++; $display("FAIL drop_result ready=%b sum=%h want 1/0a", ready, sum);
      end
      step();
   endtask

   task automatic test_reset_mid();
      logic seen;
      din = {6'd4, 6'd3, 6'd2, 6'd1}; sgn = 1'b0; chain = 1'b0; pl = 1'b1;
      step();
      pl = 1'b0;
      step();
      step();                       // past E2
      #2 rstn = 1'b1;
      #1;
      n_vec++;
      if (sum !== '0 || ready !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0 || drop !== 1'b0) begin
         n_err++; $display("FAIL reset_mid sum=%h rdy=%b busy=%b ovf=%b drop=%b want all 0",
                           sum, ready, busy, ovf, drop);
      end
      rstn = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (ready === 1'b1 || busy === 1'b1) seen = 1'b1;
      end
      n_vec++;
      if (seen !== 1'b0) begin n_err++; $display("FAIL reset_mid_no_ready got %b want 0", seen); end
      do_frame(6'd5, 6'd6, 6'd7, 6'd8, 1'b0, 1'b0, 8'd26, 1'b0, 1'b0, "after_reset");
   endtask

   task automatic test_l2_single();
      din2 = {6'd4, 6'd3, 6'd2, 6'd1}; sgn2 = 1'b0; chain2 = 1'b0; pl2 = 1'b1;
      step();                       // E0
      pl2 = 1'b0;
      step();                       // E1
      n_vec++;
      if (busy2 !== 1'b1 || ready2 !== 1'b0) begin
         n_err++; $display("FAIL l2_E1 busy=%b ready=%b want 1/0", busy2, ready2);
      end
      step();                       // E2
      n_vec++;
      if (ready2 !== 1'b1 || busy2 !== 1'b0 || sum2 !== 8'd10) begin
         n_err++; $display("FAIL l2_E2 ready=%b busy=%b sum=%h want 1/0/0a", ready2, busy2, sum2);
      end
      step();
      n_vec++;
      if (ready2 !== 1'b0) begin n_err++; $display("FAIL l2_E3 ready=%b want 0", ready2); end
   endtask

   task automatic test_back_to_back();
      logic exp_r;
      din2 = {6'd1, 6'd1, 6'd1, 6'd1}; sgn2 = 1'b0; chain2 = 1'b0; pl2 = 1'b1;
      step();                       // E0
      for (int i = 1; i < 12; i++) begin
         step();
         exp_r = (i % 3 == 2);
         n_vec++;
         if (ready2 !== exp_r || (exp_r && sum2 !== 8'd4)) begin
            n_err++; $display("FAIL b2b cycle%0d ready=%b sum=%h want %b/04", i, ready2, sum2, exp_r);
         end
      end
      pl2 = 1'b0;
      for (int i = 0; i < 4; i++) step();
      n_vec++;
      if (busy2 !== 1'b0) begin n_err++; $display("FAIL b2b_idle busy=%b want 0", busy2); end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_chain();
      test_drop();
      test_reset_mid();
      test_l2_single();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/serial_accumulator_mc.md
# serial_accumulator_mc

Parametrised frame accumulator. A frame is K words of W bits, loaded in parallel and summed L words per cycle into a widened result. Adds several things the baseline accumulator lacks: a per-frame signed/unsigned mode, a chained-frame mode (the new frame is added onto the previous result), a sticky overflow flag, back-to-back loading and a load-drop indication. It sits after the data-packing stage and feeds the result register bank.

## Interface
- W, 6: width of one input word
- K, 4: words per frame, ≥2
- L, 1: words added per cycle; must divide K; cycles per frame C = K/L
- SW, W+$clog2(K): result width (derived, not overridden)

- clk  in  1  clock; all state updates on the rising edge
- rstn  in  1  reset. One clock; reset is asynchronous and active-high.
- din  in  W*K  frame; word i at din[i*W +: W]; word 0 is summed first
- pl  in  1  parallel-load request, sampled on the clk edge
- sgn  in  1  sampled with pl; 1 = words are two's complement
- chain  in  1  sampled with pl; 1 = accumulator starts from the current sum, 0 = starts from 0
- busy  out  1  high while the frame is being summed (state RUN)
- ready  out  1  one-cycle pulse: sum holds a new result
- sum  out  SW  result; held until the next completion
- ovf  out  1  sticky overflow for chained frames
- drop  out  1  one-cycle pulse: a pl was ignored

## Operation
- States:
  - IDLE: waiting for a load.
  - RUN: summing the frame.
  - DONE: result just written.
- Load acceptance:
  - A pl sampled in IDLE or DONE is accepted.
  - On acceptance, capture din, sgn and chain into internal registers.
  - Set acc to sum if chain=1, otherwise 0. Clear idx. Enter RUN.
- Pl during RUN:
  - The pl is ignored.
  - Register drop=1 for one cycle.
  - Captured data and progress are unaffected.
- Each RUN edge:
  - Compute acc + word[idx*L] + … + word[idx*L+L-1], then increment idx.
  - Each word is extended to SW bits: sign-extended if the captured sgn=1, zero-extended otherwise.
- Last RUN edge (idx = C-1):
  - sum <= final total.
  - ready <= 1.
  - Enter DONE.
- DONE lasts one cycle. The next state is RUN if pl=1, otherwise IDLE.
- Width rules:
  - A non-chained frame cannot overflow SW bits.
  - Chained frames wrap modulo 2^SW.
- Overflow flag:
  - Any addition in a chained frame that overflows sets ovf. Unsigned: carry out of bit SW-1. Signed: operands of equal sign give a result of the other sign.
  - ovf is sticky until the next accepted pl with chain=0.
  - That clear takes effect on the acceptance edge.
- Mode changes: sgn and chain may differ frame to frame. Only the captured values are used.
- Reset (asserted at any time, including mid-frame):
  - state=IDLE; idx, acc and captured data are cleared.
  - Outputs: sum=0, ready=0, busy=0, ovf=0, drop=0.
  - No ready is produced for the aborted frame.
  - pl is ignored while rstn=1.

## Timing
- Load accepted on edge E0 → busy=1 from E0.
- Last add on edge E_C:
  - At E_C: busy=0, ready=1, sum valid.
  - At E_C+1: ready=0.
- Latency: C edges from the load edge to the result. K=4, L=1 → 4 cycles; L=2 → 2 cycles.
- Back-to-back: pl held high in DONE starts the next frame at E_C+1. Throughput is one frame per C+1 cycles.
- drop rises on the edge after the offending pl and lasts one cycle.
- ovf updates on the same edge as the addition that overflows.
- sum changes only on a completion edge or on reset.

## Test plan
- Default parameters (W=6, K=4, L=1).
  - Unsigned frame: pl=1, sgn=0, chain=0, words 1,2,3,4 → busy for 4 cycles; at E4 sum=10 and ready pulses once; ovf=0.
  - Unsigned maximum: all words 63 → sum=252, ovf=0.
  - Signed frame: words 0x3F, 0x20, 0x05, 0x0A with sgn=1 → sum=0xEE (-18).
  - Chain and overflow:
    - Frame 10, then chain=1 with words 1,1,1,1 → sum=14.
    - Frame 252, then chain=1 with all 63 → sum=248 (504 mod 256), ovf=1.
    - Next chain=0 frame → ovf clears at its load edge.
  - Hazards:
    - pl pulsed at E2 of a running frame → drop=1 for one cycle; the result equals the original frame.
    - rstn pulsed between E2 and E3 → all outputs 0 immediately; no ready follows.
    - A new load afterwards completes normally.
- L=2, words 1,2,3,4 → ready at E2 with sum=10.
- L=2, back-to-back loads with pl held high → ready pulses every 3 cycles.
